// File: rtl/fetch_sequencer_if.sv
// Instruction-memory, decode and redirect signals of the fetch sequencer.
// The master modport is the sequencer; slave is the surrounding core/memory.
interface fetch_sequencer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fault, fetch_count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fault, fetch_count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and sequences one-at-a-time instruction fetch,
// holding each returned word for decode and honouring jump/branch redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] fetch_count_q;
  logic        fault_q;
  logic        drop;
  logic        active;
  logic        redirect_ok;
  logic        redirect_bad;

  // Redirects only matter while a fetch/decode cycle is in progress.
  assign active       = (state == FETCH) || (state == WAIT) || (state == HOLD);
  assign redirect_ok  = active && bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign redirect_bad = active && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  assign bus.imem_req_valid = (state == FETCH) && !bus.redirect_valid;
  assign bus.imem_addr      = pc;
  assign bus.instr_valid    = (state == HOLD) && !bus.redirect_valid;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.fault          = fault_q;
  assign bus.fetch_count    = fetch_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      fetch_count_q <= 32'h0;
      fault_q       <= 1'b0;
      drop          <= 1'b0;
    end else if (redirect_bad) begin
      fault_q <= 1'b1;
      state   <= HALT;
    end else if (redirect_ok) begin
      pc <= bus.redirect_pc;
      // An unanswered request must still drain; its response is discarded later.
      if ((state == WAIT) && !bus.imem_rsp_valid) begin
        drop  <= 1'b1;
        state <= WAIT;
      end else begin
        drop  <= 1'b0;
        state <= FETCH;
      end
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.imem_req_valid && bus.imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= FETCH;
            end else begin
              instr_q    <= bus.imem_rsp_data;
              instr_pc_q <= pc;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            pc            <= pc + 32'd4;
            fetch_count_q <= fetch_count_q + 32'd1;
            state         <= FETCH;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench: expected delivery stream is the architectural
// PC sequence (reset PC, +4 per consumed instruction, redirect targets).
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Expected PC of the next instruction decode should receive.
  logic [31:0] exp_q[$];
  bit          halted = 1'b0;
  int          mode_g = 0;

  bit          pending;
  int          cd;
  logic [31:0] paddr;
  int          rst_cnt;
  int          stale;
  bit          last_bad;
  int          halt_cnt;
  bit          hs;
  logic [31:0] hs_addr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    logic [31:0] tgt;
    bit          released;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs      = bus.imem_req_valid && bus.imem_req_ready && !rst;
      hs_addr = bus.imem_addr;
      @(posedge clk);
      #1;
      if (last_bad) halted = 1'b1;
      last_bad           = 1'b0;
      released           = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = $urandom;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      if (rst) begin
        rst_cnt--;
        if (rst_cnt <= 0) begin
          rst      = 1'b0;
          stale    = 2;
          released = 1'b1;
        end
      end else if (halted) begin
        halt_cnt++;
        if (halt_cnt >= 12) begin
          rst      = 1'b1;
          rst_cnt  = 2;
          halted   = 1'b0;
          halt_cnt = 0;
          pending  = 1'b0;
          exp_q.delete();
          exp_q.push_back(RESET_PC);
        end
      end
      if (!rst) begin
        // Memory: one response per accepted request, 1..3 cycles later.
        if (hs) begin
          checkOutput("single_outstanding", 32'(pending), 32'd0);
          pending = 1'b1;
          paddr   = hs_addr;
          cd      = (mode_g == 0) ? 1 : int'($urandom_range(1, 3));
        end
        if (pending) begin
          if (cd == 1) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = paddr ^ XOR_KEY;
            pending            = 1'b0;
          end else begin
            cd--;
          end
        end else if (stale > 0) begin
          bus.imem_rsp_valid = 1'b1;
        end
        if (stale > 0) stale--;
        bus.imem_req_ready = (mode_g == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.instr_ready    = (mode_g == 0) ? 1'b1 : ($urandom_range(0, 4) >= 2);
        if (mode_g != 0 && !released && $urandom_range(0, 19) == 0) begin
          case ($urandom_range(0, 3))
            0:       tgt = $urandom & 32'h0000_0FFC;
            1:       tgt = 32'h0000_0100;
            2:       tgt = 32'hFFFF_FFF8;
            default: tgt = 32'h0000_0040;
          endcase
          if (mode_g == 2 && $urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = tgt;
          if (!halted) begin
            if (tgt[1:0] != 2'b00) begin
              last_bad = 1'b1;
            end else begin
              exp_q.delete();
              exp_q.push_back(tgt);
            end
          end
        end
      end
    end
  endtask

  // Monitor: compares every cycle against the scoreboard and counters.
  initial begin
    int          since;
    int          cyc;
    int          prev_del;
    int          exp_count;
    bit          stalled_prev;
    logic [31:0] saved_instr;
    logic [31:0] saved_pc;
    logic [31:0] e;
    since = 0; cyc = 0; prev_del = -1; exp_count = 0; stalled_prev = 1'b0;
    saved_instr = 32'h0; saved_pc = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        since        = 0;
        exp_count    = 0;
        prev_del     = -1;
        stalled_prev = 1'b0;
        checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
        checkOutput("rst_instr", bus.instr, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        checkOutput("rst_fault", 32'(bus.fault), 32'd0);
        checkOutput("rst_fetch_count", bus.fetch_count, 32'h0);
      end else begin
        since++;
        checkOutput("fetch_count", bus.fetch_count, 32'(exp_count));
        checkOutput("fault", 32'(bus.fault), 32'(halted));
        if (since == 1) checkOutput("idle_no_req", 32'(bus.imem_req_valid), 32'd0);
        if (since == 2) checkOutput("first_req", 32'(bus.imem_req_valid), 32'(!bus.redirect_valid));
        if (halted) checkOutput("halt_quiet", {30'd0, bus.imem_req_valid, bus.instr_valid}, 32'd0);
        if (bus.redirect_valid) checkOutput("redirect_masks", {30'd0, bus.imem_req_valid, bus.instr_valid}, 32'd0);
        checkOutput("req_vs_hold", 32'(bus.imem_req_valid && bus.instr_valid), 32'd0);
        if (stalled_prev && bus.instr_valid) begin
          checkOutput("stall_instr", bus.instr, saved_instr);
          checkOutput("stall_instr_pc", bus.instr_pc, saved_pc);
        end
        stalled_prev = bus.instr_valid && !bus.instr_ready;
        saved_instr  = bus.instr;
        saved_pc     = bus.instr_pc;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          if (exp_q.size() == 0) checkOutput("req_addr_noexp", bus.imem_addr, 32'hDEAD_BEEF);
          else checkOutput("req_addr", bus.imem_addr, exp_q[0]);
        end
        if (bus.instr_valid && bus.instr_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("delivery_noexp", bus.instr_pc, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            checkOutput("instr_pc", bus.instr_pc, e);
            checkOutput("instr", bus.instr, e ^ XOR_KEY);
            exp_q.push_back(e + 32'd4);
          end
          exp_count++;
          if (mode_g == 0) begin
            if (prev_del < 0) checkOutput("first_delivery_cycle", 32'(since), 32'd4);
            else checkOutput("cadence", 32'(cyc - prev_del), 32'd3);
            prev_del = cyc;
          end else begin
            prev_del = -1;
          end
        end
      end
    end
  end

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    pending  = 1'b0;
    cd       = 0;
    paddr    = 32'h0;
    rst_cnt  = 3;
    stale    = 0;
    last_bad = 1'b0;
    halt_cnt = 0;
    exp_q.push_back(RESET_PC);
    mode_g = 0;
    applyStimulus(40);
    mode_g = 1;
    applyStimulus(1500);
    mode_g = 2;
    applyStimulus(3000);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the architectural program counter of the RISC-V core and sequences instruction fetch around the PC-select datapath. It issues one instruction-memory read at a time, holds the returned word for decode, and advances the PC by 4 on consumption. A redirect input loads the jump/branch target produced by the PC-select logic and squashes any fetch in flight. Sits between instruction memory and decode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  request address (= current PC)
- imem_rsp_valid  in  1  read data valid (single-cycle pulse)
- imem_rsp_data  in  32  read data
- instr_valid  out  1  held instruction valid for decode
- instr_ready  in  1  decode consumes instruction
- instr  out  32  held instruction word
- instr_pc  out  32  PC of held instruction
- redirect_valid  in  1  taken jump/branch; load redirect_pc
- redirect_pc  in  32  new PC (from PC-select logic)
- fault  out  1  sticky: misaligned redirect target
- fetch_count  out  32  instructions delivered to decode since reset

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALT. At most one request outstanding.
- IDLE: entered on reset; -> FETCH on the next clock edge.
- FETCH: imem_req_valid = !redirect_valid; imem_addr = pc. On req handshake -> WAIT. Any imem_rsp_valid in FETCH is ignored.
- WAIT: on imem_rsp_valid, capture instr <= imem_rsp_data, instr_pc <= pc; -> HOLD.
- HOLD: instr_valid = !redirect_valid. On instr_valid && instr_ready: pc <= pc + 4, fetch_count += 1; -> FETCH.
- Redirect (any of FETCH/WAIT/HOLD), aligned target (redirect_pc[1:0]==0): pc <= redirect_pc; held instruction dropped (not counted).
  - FETCH/HOLD -> FETCH.
  - WAIT with no response that cycle: set drop flag, stay in WAIT; the next response is discarded, drop cleared, -> FETCH. A later redirect while drop is set overwrites pc again.
  - WAIT with response the same cycle: response discarded, -> FETCH, drop not set.
- Misaligned redirect target: fault <= 1, -> HALT; pc unchanged. HALT: no requests, instr_valid = 0, responses ignored; exit only by reset.
- Redirect in IDLE/HALT is ignored.
- Arithmetic: pc + 4 and fetch_count are modulo 2^32 (32'hFFFF_FFFC -> 0; counter wraps to 0).
- Instruction memory shares rst; a response belonging to a request issued before reset may arrive in FETCH and is ignored.

## Timing
- Reset values: state IDLE, pc = RESET_PC, imem_addr = RESET_PC, imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0, fault = 0, fetch_count = 0, drop = 0.
- First request: imem_req_valid = 1 in the second cycle after rst deasserts.
- With zero-wait memory (ready = 1, response one cycle after acceptance) and ready decode: one instruction per 3 cycles (FETCH, WAIT, HOLD).
- imem_req_valid and instr_valid depend combinationally on redirect_valid; all other outputs are registered.
- redirect takes effect on the edge it is sampled; the new target appears on imem_addr in the following FETCH cycle.

## Test plan
- Reset, zero-wait memory returning addr ^ 32'hA5A5_A5A5, decode always ready -> imem_addr 0, 4, 8; instr_pc matches; fetch_count = 3 after the third HOLD handshake; 3-cycle cadence.
- Decode stalls (instr_ready = 0) for 5 cycles in HOLD -> instr/instr_pc stable, no new request, pc unchanged; accepted on cycle 6.
- Redirect to 32'h0000_0100 while in WAIT, response 2 cycles later -> response discarded, instr_valid stays 0, next imem_addr = 32'h100, fetch_count unchanged.
- Redirect to 32'h40 in HOLD with instr_ready = 1 the same cycle -> instr_valid = 0, instruction not counted, next imem_addr = 32'h40.
- RESET_PC = 32'hFFFF_FFFC, one instruction consumed -> next imem_addr = 0.
- Redirect to 32'h0000_0102 -> fault = 1, imem_req_valid held 0 for 10+ cycles; rst pulse clears fault and restarts fetch at RESET_PC.
